// File: rtl/sram_to_sram_pkg.sv
// Shared types for the SRAM-to-SRAM store stage: FSM states and default widths.
// The lane-0 -> mem2 / lane-1 -> mem3 write side pulls its defaults from here.
package sram_to_sram_pkg;

   localparam int DEF_ADDR_BITS = 10;
   localparam int DEF_DATA_BITS = 64;

   // One bit wider than an address so a full-memory job count (2^ADDR_BITS) fits.
   typedef logic [DEF_ADDR_BITS:0] cnt_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      LAST = 2'd2
   } state_e;

endpackage

// File: rtl/sram_to_sram_store_if.sv
// Two-lane valid-only stream feeding the store stage (no backpressure).
interface sram_to_sram_store_if #(
   parameter int DATA_BITS = 64
) ();

   logic [DATA_BITS-1:0] s_data0;
   logic [DATA_BITS-1:0] s_data1;
   logic                 s_valid;

   modport master (
      output s_data0,
      output s_data1,
      output s_valid
   );

   modport slave (
      input s_data0,
      input s_data1,
      input s_valid
   );

endinterface

// File: rtl/sram_to_sram_wport.sv
// One SRAM write port (wen/waddr/wdata). With OUT_REG the triple is registered;
// otherwise it passes through. Address and data hold their last value when idle.
module sram_to_sram_wport #(
   parameter int ADDR_BITS = 10,
   parameter int DATA_BITS = 64,
   parameter int OUT_REG   = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cke,
   input  logic                 wen_i,
   input  logic [ADDR_BITS-1:0] waddr_i,
   input  logic [DATA_BITS-1:0] wdata_i,
   output logic                 wen_o,
   output logic [ADDR_BITS-1:0] waddr_o,
   output logic [DATA_BITS-1:0] wdata_o
);

   logic [ADDR_BITS-1:0] waddr_q, waddr_d;
   logic [DATA_BITS-1:0] wdata_q, wdata_d;

   always_comb begin
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (cke && wen_i) begin
         waddr_d = waddr_i;
         wdata_d = wdata_i;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   if (OUT_REG != 0) begin : g_reg
      logic wen_q, wen_d;

      always_comb begin
         wen_d = wen_q;
         if (cke) begin
            wen_d = wen_i;
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            wen_q <= 1'b0;
         end else begin
            wen_q <= wen_d;
         end
      end

      assign wen_o   = wen_q;
      assign waddr_o = waddr_q;
      assign wdata_o = wdata_q;
   end else begin : g_comb
      // Live beat passes straight through; between beats the held value shows.
      assign wen_o   = wen_i;
      assign waddr_o = wen_i ? waddr_i : waddr_q;
      assign wdata_o = wen_i ? wdata_i : wdata_q;
   end

endmodule

// File: rtl/sram_to_sram_store.sv
// Bounded-job store stage: writes stream lane 0 to mem2 and lane 1 to mem3 at
// sequential addresses, pulses done with the final write, flags unarmed beats.
module sram_to_sram_store
   import sram_to_sram_pkg::*;
#(
   parameter int ADDR_BITS = DEF_ADDR_BITS,
   parameter int DATA_BITS = DEF_DATA_BITS,
   parameter int OUT_REG   = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cke,
   input  logic                 start,
   input  logic [ADDR_BITS-1:0] len,
   output logic                 busy,
   output logic                 done,
   output logic                 overrun,
   output logic [ADDR_BITS:0]   wcount,
   sram_to_sram_store_if.slave  s,
   output logic                 mem2_wen,
   output logic [ADDR_BITS-1:0] mem2_waddr,
   output logic [DATA_BITS-1:0] mem2_wdata,
   output logic                 mem3_wen,
   output logic [ADDR_BITS-1:0] mem3_waddr,
   output logic [DATA_BITS-1:0] mem3_wdata
);

   typedef logic [ADDR_BITS-1:0] addr_t;
   typedef logic [DATA_BITS-1:0] data_t;
   typedef logic [ADDR_BITS:0]   wcnt_t;

   state_e state_q, state_d;
   addr_t  len_q, len_d;
   addr_t  addr_q, addr_d;
   wcnt_t  wcount_q, wcount_d;
   logic   overrun_q, overrun_d;
   logic   wr;
   logic   final_beat;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      addr_d     = addr_q;
      wcount_d   = wcount_q;
      overrun_d  = overrun_q;
      wr         = 1'b0;
      final_beat = 1'b0;
      if (cke) begin
         unique case (state_q)
            IDLE: begin
               if (s.s_valid) begin
                  overrun_d = 1'b1;
               end
               // A beat arriving with start is still dropped, so it re-flags overrun.
               if (start) begin
                  len_d     = len;
                  addr_d    = '0;
                  wcount_d  = '0;
                  overrun_d = s.s_valid;
                  state_d   = RUN;
               end
            end
            RUN: begin
               if (s.s_valid) begin
                  wr       = 1'b1;
                  addr_d   = addr_q + addr_t'(1);
                  wcount_d = wcount_q + wcnt_t'(1);
                  if (addr_q == len_q) begin
                     final_beat = 1'b1;
                     state_d    = (OUT_REG != 0) ? LAST : IDLE;
                  end
               end
            end
            LAST: begin
               if (s.s_valid) begin
                  overrun_d = 1'b1;
               end
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         len_q     <= '0;
         addr_q    <= '0;
         wcount_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         addr_q    <= addr_d;
         wcount_q  <= wcount_d;
         overrun_q <= overrun_d;
      end
   end

   // done/busy line up with whichever cycle the final write reaches the ports.
   assign done    = (OUT_REG != 0) ? (state_q == LAST) : final_beat;
   assign busy    = (OUT_REG != 0) ? (state_q == RUN) : ((state_q == RUN) && !final_beat);
   assign overrun = overrun_q;
   assign wcount  = wcount_q;

   data_t      lane_data  [2];
   logic [1:0] port_wen;
   addr_t      port_waddr [2];
   data_t      port_wdata [2];

   assign lane_data[0] = s.s_data0;
   assign lane_data[1] = s.s_data1;

   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      sram_to_sram_wport #(
         .ADDR_BITS (ADDR_BITS),
         .DATA_BITS (DATA_BITS),
         .OUT_REG   (OUT_REG)
      ) u_wport (
         .clk     (clk),
         .reset_n (reset_n),
         .cke     (cke),
         .wen_i   (wr),
         .waddr_i (addr_q),
         .wdata_i (lane_data[gi]),
         .wen_o   (port_wen[gi]),
         .waddr_o (port_waddr[gi]),
         .wdata_o (port_wdata[gi])
      );
   end

   assign mem2_wen   = port_wen[0];
   assign mem2_waddr = port_waddr[0];
   assign mem2_wdata = port_wdata[0];
   assign mem3_wen   = port_wen[1];
   assign mem3_waddr = port_waddr[1];
   assign mem3_wdata = port_wdata[1];

endmodule

// File: tb/tb_sram_to_sram_store.sv
// Bench for sram_to_sram_store: registered (OUT_REG=1) and pass-through (OUT_REG=0)
// instances share one stimulus stream and are checked against a job-level model.
module tb_sram_to_sram_store;

   localparam int AB = 10;
   localparam int DB = 64;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cke;
   logic          start;
   logic [AB-1:0] len;

   logic          busy1, done1, ovr1, wen2_1, wen3_1;
   logic [AB:0]   wc1;
   logic [AB-1:0] wa2_1, wa3_1;
   logic [DB-1:0] wd2_1, wd3_1;
   logic          busy0, done0, ovr0, wen2_0, wen3_0;
   logic [AB:0]   wc0;
   logic [AB-1:0] wa2_0, wa3_0;
   logic [DB-1:0] wd2_0, wd3_0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   sram_to_sram_store_if #(.DATA_BITS(DB)) sif ();

   sram_to_sram_store #(.ADDR_BITS(AB), .DATA_BITS(DB), .OUT_REG(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .cke(cke), .start(start), .len(len),
      .busy(busy1), .done(done1), .overrun(ovr1), .wcount(wc1), .s(sif),
      .mem2_wen(wen2_1), .mem2_waddr(wa2_1), .mem2_wdata(wd2_1),
      .mem3_wen(wen3_1), .mem3_waddr(wa3_1), .mem3_wdata(wd3_1)
   );

   sram_to_sram_store #(.ADDR_BITS(AB), .DATA_BITS(DB), .OUT_REG(0)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .cke(cke), .start(start), .len(len),
      .busy(busy0), .done(done0), .overrun(ovr0), .wcount(wc0), .s(sif),
      .mem2_wen(wen2_0), .mem2_waddr(wa2_0), .mem2_wdata(wd2_0),
      .mem3_wen(wen3_0), .mem3_waddr(wa3_0), .mem3_wdata(wd3_0)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   // Job-level reference: "armed" means a job still owes writes; "tail" is the
   // one cycle where the registered variant shows its final write.
   bit            m1_armed, m1_tail, m1_fin, m1_wen;
   logic [AB-1:0] m1_next, m1_len, m1_addr;
   int            m1_wc;
   bit            m1_ovr;
   logic [DB-1:0] m1_d2, m1_d3;
   bit            m0_armed;
   logic [AB-1:0] m0_next, m0_len, m0_addr;
   int            m0_wc;
   bit            m0_ovr;
   logic [DB-1:0] m0_d2, m0_d3;

   task automatic model_reset();
      m1_armed = 0; m1_tail = 0; m1_wen = 0; m1_next = '0; m1_len = '0; m1_addr = '0;
      m1_wc = 0; m1_ovr = 0; m1_d2 = '0; m1_d3 = '0;
      m0_armed = 0; m0_next = '0; m0_len = '0; m0_addr = '0;
      m0_wc = 0; m0_ovr = 0; m0_d2 = '0; m0_d3 = '0;
   endtask

   always @(posedge clk) begin
      if (!reset_n) begin
         model_reset();
      end else if (cke) begin
         m1_fin = 0;
         m1_wen = 0;
         if (m1_armed && sif.s_valid) begin
            m1_wen  = 1; m1_addr = m1_next; m1_d2 = sif.s_data0; m1_d3 = sif.s_data1;
            m1_wc   = m1_wc + 1;
            m1_fin  = (m1_next == m1_len);
            m1_next = m1_next + 1'b1;
            if (m1_fin) m1_armed = 0;
         end else if (!m1_armed) begin
            if (sif.s_valid) m1_ovr = 1;
            if (start && !m1_tail) begin
               m1_len = len; m1_next = '0; m1_wc = 0; m1_ovr = sif.s_valid; m1_armed = 1;
            end
         end
         m1_tail = m1_fin;

         if (m0_armed && sif.s_valid) begin
            m0_addr = m0_next; m0_d2 = sif.s_data0; m0_d3 = sif.s_data1;
            m0_wc   = m0_wc + 1;
            if (m0_next == m0_len) m0_armed = 0;
            m0_next = m0_next + 1'b1;
         end else if (!m0_armed) begin
            if (sif.s_valid) m0_ovr = 1;
            if (start) begin
               m0_len = len; m0_next = '0; m0_wc = 0; m0_ovr = sif.s_valid; m0_armed = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      bit w0, d0;
      if (!reset_n) model_reset();
      chk("r1_wen2", wen2_1, m1_wen);
      chk("r1_wen3", wen3_1, m1_wen);
      chk("r1_waddr2", wa2_1, m1_addr);
      chk("r1_waddr3", wa3_1, m1_addr);
      chk("r1_wdata2", wd2_1, m1_d2);
      chk("r1_wdata3", wd3_1, m1_d3);
      chk("r1_done", done1, m1_tail);
      chk("r1_busy", busy1, m1_armed);
      chk("r1_wcount", wc1, m1_wc);
      chk("r1_overrun", ovr1, m1_ovr);
      w0 = reset_n && cke && sif.s_valid && m0_armed;
      d0 = w0 && (m0_next == m0_len);
      chk("r0_wen2", wen2_0, w0);
      chk("r0_wen3", wen3_0, w0);
      chk("r0_waddr2", wa2_0, w0 ? m0_next : m0_addr);
      chk("r0_waddr3", wa3_0, w0 ? m0_next : m0_addr);
      chk("r0_wdata2", wd2_0, w0 ? sif.s_data0 : m0_d2);
      chk("r0_wdata3", wd3_0, w0 ? sif.s_data1 : m0_d3);
      chk("r0_done", done0, d0);
      chk("r0_busy", busy0, m0_armed && !d0);
      chk("r0_wcount", wc0, m0_wc);
      chk("r0_overrun", ovr0, m0_ovr);
   end

   task automatic drive(input bit st, input int ln, input bit v,
                        input logic [63:0] a, input logic [63:0] b, input bit ck);
      @(posedge clk);
      #1;
      start = st; len = AB'(ln); sif.s_valid = v; sif.s_data0 = a; sif.s_data1 = b; cke = ck;
   endtask

   typedef struct {
      bit            start;
      int            len;
      bit            valid;
      logic [DB-1:0] d0, d1;
      bit            e_wen;
      logic [AB-1:0] e_addr;
      logic [DB-1:0] e_d2, e_d3;
      bit            e_done, e_busy;
      int            e_wc;
      bit            e_ovr;
   } vec_t;

   vec_t tbl[7];

   function automatic vec_t mk(bit st, int ln, bit v, int a, int b, bit ew, int ea,
                               int e2, int e3, bit ed, bit eb, int ewc, bit eo);
      vec_t r;
      r.start = st; r.len = ln; r.valid = v; r.d0 = 64'(a); r.d1 = 64'(b);
      r.e_wen = ew; r.e_addr = AB'(ea); r.e_d2 = 64'(e2); r.e_d3 = 64'(e3);
      r.e_done = ed; r.e_busy = eb; r.e_wc = ewc; r.e_ovr = eo;
      return r;
   endfunction

   initial begin
      // Expected registered-port outputs, sampled mid-cycle of the row's own inputs.
      tbl[0] = mk(1, 3, 0,  0,  0, 0, 0,  0,  0, 0, 0, 0, 0);
      tbl[1] = mk(0, 0, 1, 10, 20, 0, 0,  0,  0, 0, 1, 0, 0);
      tbl[2] = mk(0, 0, 1, 11, 21, 1, 0, 10, 20, 0, 1, 1, 0);
      tbl[3] = mk(0, 0, 1, 12, 22, 1, 1, 11, 21, 0, 1, 2, 0);
      tbl[4] = mk(0, 0, 1, 13, 23, 1, 2, 12, 22, 0, 1, 3, 0);
      tbl[5] = mk(0, 0, 0,  0,  0, 1, 3, 13, 23, 1, 0, 4, 0);
      tbl[6] = mk(0, 0, 0,  0,  0, 0, 3, 13, 23, 0, 0, 4, 0);

      reset_n = 1'b0; cke = 1'b1; start = 1'b0; len = '0;
      sif.s_valid = 1'b0; sif.s_data0 = '0; sif.s_data1 = '0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         drive(tbl[i].start, tbl[i].len, tbl[i].valid, tbl[i].d0, tbl[i].d1, 1'b1);
         @(negedge clk);
         chk("tbl_wen", wen2_1, tbl[i].e_wen);
         chk("tbl_waddr", wa3_1, tbl[i].e_addr);
         chk("tbl_wdata2", wd2_1, tbl[i].e_d2);
         chk("tbl_wdata3", wd3_1, tbl[i].e_d3);
         chk("tbl_done", done1, tbl[i].e_done);
         chk("tbl_busy", busy1, tbl[i].e_busy);
         chk("tbl_wcount", wc1, tbl[i].e_wc);
         chk("tbl_overrun", ovr1, tbl[i].e_ovr);
      end

      // Gapped job with a two-cycle clock-enable freeze (beats under cke=0 ignored).
      begin
         bit vv[10] = '{1, 0, 0, 1, 1, 1, 1, 0, 1, 0};
         bit kk[10] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
         drive(1, 3, 0, 0, 0, 1);
         for (int i = 0; i < 10; i++) drive(0, 0, vv[i], 64'(30 + i), 64'(40 + i), kk[i]);
         repeat (2) drive(0, 0, 0, 0, 0, 1);
         @(negedge clk);
         chk("gap_wcount1", wc1, 4);
         chk("gap_wcount0", wc0, 4);
      end

      // Full-memory job: 1024 beats, then a stray beat that must not be written.
      drive(1, 1023, 0, 0, 0, 1);
      for (int i = 0; i < 1024; i++) drive(0, 0, 1, 64'(i), 64'(i + 5000), 1);
      repeat (2) drive(0, 0, 0, 0, 0, 1);
      @(negedge clk);
      chk("full_wcount1", wc1, 1024);
      chk("full_wcount0", wc0, 1024);
      drive(0, 0, 1, 64'hdead, 64'hbeef, 1);
      drive(0, 0, 0, 0, 0, 1);

      // Beat while idle, then start together with a beat; next clean start clears.
      drive(0, 0, 1, 1, 2, 1);
      drive(1, 1, 1, 3, 4, 1);
      drive(0, 0, 0, 0, 0, 1);
      @(negedge clk);
      chk("ovr_set1", ovr1, 1);
      chk("ovr_set0", ovr0, 1);
      drive(0, 0, 1, 5, 6, 1);
      drive(0, 0, 1, 7, 8, 1);
      repeat (3) drive(0, 0, 0, 0, 0, 1);
      drive(1, 2, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 1);
      @(negedge clk);
      chk("ovr_clr1", ovr1, 0);
      chk("ovr_clr0", ovr0, 0);
      for (int i = 0; i < 3; i++) drive(0, 0, 1, 64'(i), 64'(i), 1);
      repeat (2) drive(0, 0, 0, 0, 0, 1);

      // Reset in the middle of a job, then a single-word job.
      drive(1, 3, 0, 0, 0, 1);
      drive(0, 0, 1, 50, 60, 1);
      drive(0, 0, 1, 51, 61, 1);
      @(posedge clk);
      #1 reset_n = 1'b0; sif.s_valid = 1'b0;
      @(negedge clk);
      chk("rst_wen", wen2_1, 0);
      chk("rst_busy", busy1, 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      drive(1, 0, 0, 0, 0, 1);
      drive(0, 0, 1, 70, 80, 1);
      repeat (2) drive(0, 0, 0, 0, 0, 1);
      @(negedge clk);
      chk("one_wcount1", wc1, 1);
      chk("one_wcount0", wc0, 1);

      // Randomized traffic, occasional cke drops and resets.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         reset_n     = ($urandom_range(0, 499) != 0);
         cke         = ($urandom_range(0, 7) != 0);
         start       = ($urandom_range(0, 7) == 0);
         len         = ($urandom_range(0, 15) == 0) ? AB'($urandom) : AB'($urandom_range(0, 7));
         sif.s_valid = ($urandom_range(0, 2) != 0);
         sif.s_data0 = {$urandom, $urandom};
         sif.s_data1 = {$urandom, $urandom};
      end
      drive(0, 0, 0, 0, 0, 1);
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
